// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready bus for the pipelined barrel shifter: operand side in, result side out.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;
  logic               out_err;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_err
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log2-layered shift/rotate unit (SLL/SRL/SRA/ROL/ROR) with tag sideband and a
// single global advance enable; PIPE selects a register per layer or one output register.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int unsigned L = SHAMT_W;
  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // Illegal ops fall through to the default arm and pass the data untouched.
  function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       op,
                                                   input int unsigned      amt);
    case (op)
      OP_SLL:  return d << amt;
      OP_SRL:  return d >> amt;
      OP_SRA:  return $signed(d) >>> amt;
      OP_ROL:  return (d << amt) | (d >> (WIDTH - amt));
      OP_ROR:  return (d >> amt) | (d << (WIDTH - amt));
      default: return d;
    endcase
  endfunction

  logic               w_adv;
  logic [WIDTH-1:0]   w_fin_data;
  logic [2:0]         w_fin_op;
  logic [TAG_W-1:0]   w_fin_tag;
  logic               w_fin_valid;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_out_zero;
  logic               r_out_err;

  // Whole pipe moves or holds together; bubbles are not squeezed out.
  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  if (PIPE != 0) begin : g_pipe
    logic [WIDTH-1:0]   r_mid_data  [L-1];
    logic [2:0]         r_mid_op    [L-1];
    logic [SHAMT_W-1:0] r_mid_shamt [L-1];
    logic [TAG_W-1:0]   r_mid_tag   [L-1];
    logic [L-2:0]       r_mid_valid;
    logic [WIDTH-1:0]   w_in  [L];
    logic [2:0]         w_op  [L];
    logic [SHAMT_W-1:0] w_sh  [L];
    logic [WIDTH-1:0]   w_res [L];

    always_comb begin
      w_in[0] = bus.in_data;
      w_op[0] = bus.in_op;
      w_sh[0] = bus.in_shamt;
      for (int k = 1; k < int'(L); k++) begin
        w_in[k] = r_mid_data[k-1];
        w_op[k] = r_mid_op[k-1];
        w_sh[k] = r_mid_shamt[k-1];
      end
      for (int k = 0; k < int'(L); k++) begin
        w_res[k] = w_sh[k][k] ? shift_layer(w_in[k], w_op[k], 32'd1 << k) : w_in[k];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mid_valid <= '0;
        for (int k = 0; k < int'(L) - 1; k++) begin
          r_mid_data[k]  <= '0;
          r_mid_op[k]    <= '0;
          r_mid_shamt[k] <= '0;
          r_mid_tag[k]   <= '0;
        end
      end else if (w_adv) begin
        r_mid_valid  <= {r_mid_valid[L-3:0], bus.in_valid};
        r_mid_tag[0] <= bus.in_tag;
        for (int k = 1; k < int'(L) - 1; k++) begin
          r_mid_tag[k] <= r_mid_tag[k-1];
        end
        for (int k = 0; k < int'(L) - 1; k++) begin
          r_mid_data[k]  <= w_res[k];
          r_mid_op[k]    <= w_op[k];
          r_mid_shamt[k] <= w_sh[k];
        end
      end
    end

    assign w_fin_data  = w_res[L-1];
    assign w_fin_op    = w_op[L-1];
    assign w_fin_tag   = r_mid_tag[L-2];
    assign w_fin_valid = r_mid_valid[L-2];
  end else begin : g_comb
    always_comb begin
      w_fin_data = bus.in_data;
      for (int k = 0; k < int'(L); k++) begin
        if (bus.in_shamt[k]) begin
          w_fin_data = shift_layer(w_fin_data, bus.in_op, 32'd1 << k);
        end
      end
    end

    assign w_fin_op    = bus.in_op;
    assign w_fin_tag   = bus.in_tag;
    assign w_fin_valid = bus.in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_zero  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_fin_valid;
      r_out_data  <= w_fin_data;
      r_out_tag   <= w_fin_tag;
      r_out_zero  <= (w_fin_data == '0);
      r_out_err   <= (w_fin_op > OP_ROR);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_zero  = r_out_zero;
  assign bus.out_err   = r_out_err;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: a 32-bit PIPE=1 and a 16-bit PIPE=0 instance,
// each scored against a whole-amount shift model, plus literal directed expectations.
module tb_pipelined_barrel_shifter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(4)) a ();
  pipelined_barrel_shifter_if #(.WIDTH(16), .TAG_W(4)) b ();

  pipelined_barrel_shifter #(.WIDTH(32), .PIPE(1), .TAG_W(4)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  pipelined_barrel_shifter #(.WIDTH(16), .PIPE(0), .TAG_W(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  typedef struct {
    logic [63:0] d;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t        q32[$];
  exp_t        q16[$];
  exp_t        e32, e16;
  int          out_cnt32 = 0;
  logic        st32 = 1'b0;
  logic [31:0] sd32;
  logic [3:0]  stag32;
  logic        stream_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Shift by the whole amount at once, fill rules straight from the mode definitions.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int sh,
                                            input logic [2:0] op, input int w);
    logic [63:0] m, r, x;
    m = (64'd1 << w) - 64'd1;
    x = d & m;
    case (op)
      3'd0:    r = x << sh;
      3'd1:    r = x >> sh;
      3'd2:    r = x[w-1] ? ((x >> sh) | (m & ~(m >> sh))) : (x >> sh);
      3'd3:    r = (x << sh) | (x >> (w - sh));
      3'd4:    r = (x >> sh) | (x << (w - sh));
      default: r = x;
    endcase
    return r & m;
  endfunction

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
      st32 = 1'b0;
    end else begin
      chk("a in_ready", a.in_ready, !a.out_valid || a.out_ready);
      if (st32) begin
        chk("a stall valid", a.out_valid, 1);
        chk("a stall data", a.out_data, sd32);
        chk("a stall tag", a.out_tag, stag32);
      end
      if (a.out_valid && a.out_ready) begin
        out_cnt32++;
        if (q32.size() == 0) begin
          chk("a unexpected out", 1, 0);
        end else begin
          e32 = q32.pop_front();
          chk("a data", a.out_data, e32.d);
          chk("a tag", a.out_tag, e32.tag);
          chk("a zero", a.out_zero, e32.d == 0);
          chk("a err", a.out_err, e32.err);
        end
      end
      st32   = a.out_valid && !a.out_ready;
      sd32   = a.out_data;
      stag32 = a.out_tag;
      if (a.in_valid && a.in_ready)
        q32.push_back('{d: ref_shift({32'd0, a.in_data}, a.in_shamt, a.in_op, 32),
                        tag: a.in_tag, err: a.in_op > 3'd4});
    end
  end

  // Scoreboard for the 16-bit instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
    end else begin
      chk("b in_ready", b.in_ready, !b.out_valid || b.out_ready);
      if (b.out_valid && b.out_ready) begin
        if (q16.size() == 0) begin
          chk("b unexpected out", 1, 0);
        end else begin
          e16 = q16.pop_front();
          chk("b data", b.out_data, e16.d);
          chk("b tag", b.out_tag, e16.tag);
          chk("b zero", b.out_zero, e16.d == 0);
          chk("b err", b.out_err, e16.err);
        end
      end
      if (b.in_valid && b.in_ready)
        q16.push_back('{d: ref_shift({48'd0, b.in_data}, b.in_shamt, b.in_op, 16),
                        tag: b.in_tag, err: b.in_op > 3'd4});
    end
  end

  // Called at posedge+1 with the 32-bit pipe drained; latency counts the accepting edge.
  task automatic run32(input string nm, input logic [31:0] d, input logic [4:0] sh,
                       input logic [2:0] op, input logic [3:0] tg,
                       input logic [31:0] exp_d, input logic exp_z, input logic exp_e);
    int lat;
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.in_data   = d;
    a.in_shamt  = sh;
    a.in_op     = op;
    a.in_tag    = tg;
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    lat = 1;
    while (!a.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, 5);
    chk({nm, " data"}, a.out_data, exp_d);
    chk({nm, " zero"}, a.out_zero, exp_z);
    chk({nm, " err"}, a.out_err, exp_e);
    chk({nm, " tag"}, a.out_tag, tg);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] pat;
    int base, k;
    pat = 4'b1001;
    a.in_valid = 1'b0; a.in_data = '0; a.in_shamt = '0; a.in_op = '0; a.in_tag = '0;
    a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_data = '0; b.in_shamt = '0; b.in_op = '0; b.in_tag = '0;
    b.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #3;
    chk("reset a in_ready", a.in_ready, 1);
    chk("reset a out_valid", a.out_valid, 0);
    chk("reset a out_data", a.out_data, 0);
    chk("reset a out_tag", a.out_tag, 0);
    chk("reset a out_zero", a.out_zero, 0);
    chk("reset a out_err", a.out_err, 0);
    chk("reset b in_ready", b.in_ready, 1);
    chk("reset b out_valid", b.out_valid, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run32("sra31", 32'h8000_0000, 5'd31, 3'd2, 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run32("sra16n", 32'h8000_0000, 5'd16, 3'd2, 4'd2, 32'hFFFF_8000, 1'b0, 1'b0);
    run32("sra16p", 32'h7FFF_0000, 5'd16, 3'd2, 4'd3, 32'h0000_7FFF, 1'b0, 1'b0);
    run32("sll1", 32'h8000_0001, 5'd1, 3'd0, 4'd4, 32'h0000_0002, 1'b0, 1'b0);
    run32("srl1", 32'h8000_0001, 5'd1, 3'd1, 4'd5, 32'h4000_0000, 1'b0, 1'b0);
    run32("rol1", 32'h8000_0001, 5'd1, 3'd3, 4'd6, 32'h0000_0003, 1'b0, 1'b0);
    run32("ror1", 32'h8000_0001, 5'd1, 3'd4, 4'd7, 32'hC000_0000, 1'b0, 1'b0);
    run32("srl0", 32'h8000_0001, 5'd0, 3'd1, 4'd8, 32'h8000_0001, 1'b0, 1'b0);
    run32("sllz", 32'h8000_0000, 5'd1, 3'd0, 4'd9, 32'h0000_0000, 1'b1, 1'b0);
    run32("illegal", 32'h1234_5678, 5'd4, 3'd6, 4'hC, 32'h1234_5678, 1'b0, 1'b1);

    // Eight-beat stream against a 1,0,0,1 output-ready pattern.
    base = out_cnt32;
    fork
      begin
        int i, g;
        i = 0;
        g = 0;
        while (i < 8 && g < 200) begin
          logic acc;
          a.in_valid = 1'b1;
          a.in_data  = 32'h1357_9BDF ^ (32'h0101_0101 * i);
          a.in_shamt = 5'(i * 3 + 1);
          a.in_op    = 3'(i % 5);
          a.in_tag   = 4'(i);
          @(negedge clk);
          acc = a.in_ready;
          @(posedge clk); #1;
          if (acc) i++;
          g++;
        end
        a.in_valid = 1'b0;
        k = 0;
        while (out_cnt32 < base + 8 && k < 200) begin
          @(posedge clk); #1;
          k++;
        end
        chk("stream count", out_cnt32 - base, 8);
        stream_done = 1'b1;
      end
      begin
        int j;
        j = 0;
        while (!stream_done && j < 400) begin
          a.out_ready = pat[j % 4];
          j++;
          @(posedge clk); #1;
        end
        a.out_ready = 1'b1;
      end
    join
    @(posedge clk); #1;

    // Fill the pipe, then drop reset between clock edges.
    for (int i = 0; i < 6; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = 32'hA5A5_0000 + i;
      a.in_shamt = 5'(i);
      a.in_op    = 3'd3;
      a.in_tag   = 4'(i + 8);
      @(posedge clk); #1;
    end
    a.in_valid = 1'b0;
    chk("pre-reset out_valid", a.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", a.out_valid, 0);
    chk("async reset in_ready", a.in_ready, 1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle", a.out_valid, 0);
    run32("post-reset", 32'h0000_F00F, 5'd4, 3'd1, 4'hE, 32'h0000_0F00, 1'b0, 1'b0);

    // 16-bit combinational variant: one register of latency, full throughput.
    b.in_valid = 1'b1;
    b.in_data  = 16'h0001;
    b.in_shamt = 4'd15;
    b.in_op    = 3'd4;
    b.in_tag   = 4'd5;
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    chk("b ror15 valid", b.out_valid, 1);
    chk("b ror15 data", b.out_data, 16'h0002);
    chk("b ror15 tag", b.out_tag, 5);
    @(posedge clk); #1;
    chk("b ror15 drained", b.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      b.in_valid = 1'b1;
      b.in_data  = 16'h8421 + 16'(i);
      b.in_shamt = 4'(i * 5);
      b.in_op    = 3'(i);
      b.in_tag   = 4'(i);
      @(posedge clk); #1;
      chk("b b2b valid", b.out_valid, 1);
      chk("b b2b tag", b.out_tag, i);
    end
    b.in_valid = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("a queue empty", q32.size(), 0);
    chk("b queue empty", q16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
